// File: rtl/activation_feed_ctrl.sv
// rtl/activation_feed_ctrl.sv - activation SRAM feed sequencer for the systolic skew buffer
// Optional feature macro: FEED_CTRL_PERF_CNT_EN adds the perf_cycles busy-cycle counter.
module activation_feed_ctrl #(
   parameter int SYSTOLIC_SIZE    = 8,
   parameter int ACTIVATION_WIDTH = 8,
   parameter int ADDR_WIDTH       = 8
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      start,
   input  logic                                      abort,
   input  logic                                      test_mode_req,
   input  logic [ADDR_WIDTH-1:0]                     base_addr,
   input  logic [ADDR_WIDTH-1:0]                     num_vectors,
   output logic                                      mem_rd_en,
   output logic [ADDR_WIDTH-1:0]                     mem_rd_addr,
   input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] mem_rd_data,
   output logic                                      test_mode,
   output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] activation_data,
   output logic                                      data_valid,
   output logic                                      busy,
`ifdef FEED_CTRL_PERF_CNT_EN
   output logic [15:0]                               perf_cycles,
`endif
   output logic                                      done
);

   localparam int SKEW_W = $clog2(SYSTOLIC_SIZE + 1);
   localparam int CNT_W  = (ADDR_WIDTH > SKEW_W) ? ADDR_WIDTH : SKEW_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_DRAIN
   } state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_mode;
   logic                    r_rd_en;
   logic [ADDR_WIDTH-1:0]   r_rd_addr;
   logic                    r_test_mode;
   logic                    r_data_valid;
   logic                    r_busy;
   logic                    r_done;
   logic                    w_accept;

   assign w_accept = (r_state == S_IDLE) && start && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_mode       <= 1'b0;
         r_rd_en      <= 1'b0;
         r_rd_addr    <= '0;
         r_test_mode  <= 1'b0;
         r_data_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         // read data lands one cycle after the strobe, so valid simply trails it
         r_data_valid <= r_rd_en;
         r_done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_test_mode <= 1'b0;
               if (w_accept) begin
                  r_mode      <= test_mode_req;
                  r_test_mode <= test_mode_req;
                  if (num_vectors != '0) begin
                     r_state   <= S_FEED;
                     r_rd_en   <= 1'b1;
                     r_rd_addr <= base_addr;
                     r_cnt     <= CNT_W'(num_vectors) - CNT_W'(1);
                     r_busy    <= 1'b1;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            S_FEED: begin
               if (abort) begin
                  r_state     <= S_IDLE;
                  r_rd_en     <= 1'b0;
                  r_rd_addr   <= '0;
                  r_busy      <= 1'b0;
                  r_test_mode <= 1'b0;
               end else if (r_cnt == '0) begin
                  r_state   <= S_DRAIN;
                  r_rd_en   <= 1'b0;
                  r_rd_addr <= '0;
                  // parallel mode needs one flush cycle, skewed mode a full array depth
                  r_cnt     <= r_mode ? '0 : CNT_W'(SYSTOLIC_SIZE - 1);
               end else begin
                  r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                  r_cnt     <= r_cnt - CNT_W'(1);
               end
            end
            S_DRAIN: begin
               if (abort) begin
                  r_state     <= S_IDLE;
                  r_busy      <= 1'b0;
                  r_test_mode <= 1'b0;
               end else if (r_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_rd_en <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef FEED_CTRL_PERF_CNT_EN
   logic [15:0] r_perf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf <= '0;
      end else if (w_accept) begin
         r_perf <= '0;
      end else if (r_busy && (r_perf != 16'hFFFF)) begin
         r_perf <= r_perf + 16'd1;
      end
   end

   assign perf_cycles = r_perf;
`endif

   assign mem_rd_en       = r_rd_en;
   assign mem_rd_addr     = r_rd_addr;
   assign test_mode       = r_test_mode;
   assign data_valid      = r_data_valid;
   assign busy            = r_busy;
   assign done            = r_done;
   // zeros between vectors flush the downstream skew registers
   assign activation_data = r_data_valid ? mem_rd_data : '0;

endmodule

// File: tb/tb_activation_feed_ctrl.sv
// tb/tb_activation_feed_ctrl.sv - randomized model-checked bench for activation_feed_ctrl
module tb_activation_feed_ctrl;
   localparam int S    = 8;
   localparam int AW   = 8;
   localparam int DW   = 64;
   localparam int MAXC = 4096;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, abort, test_mode_req;
   logic [AW-1:0] base_addr, num_vectors;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic          test_mode;
   logic [DW-1:0] activation_data;
   logic          data_valid, busy, done;
`ifdef FEED_CTRL_PERF_CNT_EN
   logic [15:0]   perf_cycles;
`endif

   always #5 clk = ~clk;

   activation_feed_ctrl #(.SYSTOLIC_SIZE(S), .ACTIVATION_WIDTH(8), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .test_mode_req(test_mode_req), .base_addr(base_addr), .num_vectors(num_vectors),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .test_mode(test_mode), .activation_data(activation_data), .data_valid(data_valid),
      .busy(busy),
`ifdef FEED_CTRL_PERF_CNT_EN
      .perf_cycles(perf_cycles),
`endif
      .done(done));

   function automatic logic [DW-1:0] pat(input logic [7:0] a);
      logic [DW-1:0] r;
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = a ^ 8'(i * 37 + 1);
      return r;
   endfunction

   // SRAM with one-cycle latency; garbage when not read checks the zero flush
   always @(posedge clk) mem_rd_data <= mem_rd_en ? pat(mem_rd_addr) : {$urandom, $urandom};

   // Expected per-cycle outputs, planned per operation
   bit        exp_rd_en [MAXC];
   bit [7:0]  exp_addr  [MAXC];
   bit        exp_dv    [MAXC];
   bit        exp_busy  [MAXC];
   bit        exp_done  [MAXC];
   bit        exp_tm    [MAXC];
   bit [15:0] exp_perf  [MAXC];
   bit [15:0] m_perf;
   int        cyc;
   int        checks, failures;

   int        obs_busy, obs_done, obs_rden, obs_last_done;
   logic [7:0] obs_addrs[$];

   function automatic void chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, expv);
      end
   endfunction

   always @(negedge clk) begin
      chk("mem_rd_en", mem_rd_en, exp_rd_en[cyc]);
      if (exp_rd_en[cyc]) chk("mem_rd_addr", mem_rd_addr, exp_addr[cyc]);
      chk("data_valid", data_valid, exp_dv[cyc]);
      chk("activation_data", activation_data,
          (exp_dv[cyc] && cyc > 0) ? pat(exp_addr[cyc-1]) : '0);
      chk("busy", busy, exp_busy[cyc]);
      chk("done", done, exp_done[cyc]);
      chk("test_mode", test_mode, exp_tm[cyc]);
`ifdef FEED_CTRL_PERF_CNT_EN
      chk("perf_cycles", perf_cycles, exp_perf[cyc]);
`endif
      if (busy) obs_busy++;
      if (done) begin obs_done++; obs_last_done = cyc; end
      if (mem_rd_en) begin obs_rden++; obs_addrs.push_back(mem_rd_addr); end
   end

   task automatic clear_obs();
      obs_busy = 0; obs_done = 0; obs_rden = 0; obs_last_done = -1;
      obs_addrs.delete();
   endtask

   task automatic plan(input int k, input logic tmr, input logic [7:0] b, input int n);
      int d;
      d = tmr ? 1 : S;
      if (n == 0) begin
         exp_done[k+1] = 1; exp_tm[k+1] = tmr;
      end else begin
         for (int j = 0; j < n; j++) begin
            exp_rd_en[k+1+j] = 1;
            exp_addr[k+1+j]  = b + 8'(j);
            exp_dv[k+2+j]    = 1;
         end
         for (int c = k + 1; c <= k + n + d; c++) begin
            exp_busy[c] = 1; exp_tm[c] = tmr;
         end
         exp_tm[k+n+d+1]   = tmr;
         exp_done[k+n+d+1] = 1;
      end
   endtask

   task automatic kill_after(input int k, input bit incl);
      for (int c = k + (incl ? 0 : 1); c < k + 300 && c < MAXC; c++) begin
         exp_rd_en[c] = 0; exp_busy[c] = 0; exp_done[c] = 0; exp_tm[c] = 0;
         if (incl || c > k + 1) exp_dv[c] = 0;
         if (incl) exp_perf[c] = 0;
      end
   endtask

   task automatic cyc_in(input logic st, input logic ab, input logic tmr,
                         input logic [7:0] b, input logic [7:0] n);
      bit acc;
      int k;
      k = cyc;
      start = st; abort = ab; test_mode_req = tmr; base_addr = b; num_vectors = n;
      acc = st && !ab && !exp_busy[k];
      if (ab && exp_busy[k]) kill_after(k, 0);
      if (acc) plan(k, tmr, b, int'(n));
      if (acc) m_perf = 0;
      else if (exp_busy[k] && m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
      exp_perf[k+1] = m_perf;
      @(posedge clk); #1; cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc_in(1'b0, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
   endtask

   task automatic do_reset(input int n);
      start = 0; abort = 0; rst_n = 0;
      kill_after(cyc, 1);
      m_perf = 0;
      for (int i = 0; i < n; i++) begin
         exp_perf[cyc+1] = 0;
         @(posedge clk); #1; cyc++;
      end
      rst_n = 1;
   endtask

   initial begin
      int t0;
      logic [7:0] wexp[4];
      checks = 0; failures = 0; cyc = 0; m_perf = 0;
      rst_n = 0; start = 0; abort = 0; test_mode_req = 0; base_addr = 0; num_vectors = 0;
      clear_obs();
      repeat (2) @(posedge clk);
      #1; rst_n = 1;

      // skewed mode, base 0x10, three vectors
      clear_obs(); t0 = cyc;
      cyc_in(1, 0, 0, 8'h10, 8'd3); idle(14);
      chk("pin_done_cycle", obs_last_done - t0, 12);
      chk("pin_busy_cycles", obs_busy, 11);
      chk("pin_done_count", obs_done, 1);
      chk("pin_rden_count", obs_rden, 3);
`ifdef FEED_CTRL_PERF_CNT_EN
      chk("pin_perf", perf_cycles, 11);
`endif

      // parallel mode, same stimulus
      clear_obs(); t0 = cyc;
      cyc_in(1, 0, 1, 8'h10, 8'd3); idle(8);
      chk("pin_par_done_cycle", obs_last_done - t0, 5);
      chk("pin_par_busy_cycles", obs_busy, 4);

      // address wrap
      clear_obs();
      cyc_in(1, 0, 0, 8'hFE, 8'd4); idle(14);
      wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00; wexp[3] = 8'h01;
      chk("pin_wrap_count", obs_addrs.size(), 4);
      for (int i = 0; i < obs_addrs.size() && i < 4; i++) chk("pin_wrap_addr", obs_addrs[i], wexp[i]);

      // zero-length request
      clear_obs(); t0 = cyc;
      cyc_in(1, 0, 0, 8'h10, 8'd0); idle(3);
      chk("pin_n0_done_cycle", obs_last_done - t0, 1);
      chk("pin_n0_rden", obs_rden, 0);

      // abort in FEED, with an ignored start while busy
      clear_obs();
      cyc_in(1, 0, 0, 8'h10, 8'd3); cyc_in(1, 0, 1, 8'h40, 8'd9);
      cyc_in(0, 1, 0, 8'h00, 8'd0); idle(14);
      chk("pin_abort_busy", obs_busy, 2);
      chk("pin_abort_done", obs_done, 0);

      // start together with abort in IDLE
      clear_obs();
      cyc_in(1, 1, 0, 8'h10, 8'd3); idle(5);
      chk("pin_startabort_busy", obs_busy, 0);
      chk("pin_startabort_done", obs_done, 0);

      // reset mid-operation
      clear_obs();
      cyc_in(1, 0, 0, 8'h10, 8'd3); idle(1); do_reset(2); idle(15);
      chk("pin_reset_busy", obs_busy, 1);
      chk("pin_reset_done", obs_done, 0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 3)));
         else cyc_in($urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, 1'($urandom),
                     8'($urandom), 8'($urandom_range(0, 12)));
      end
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
